lu_blk_responder: RTL and testbench
===================================

LU_BLK_RESPONDER -- requirements
Module: lu_blk_responder

Interface
REQ-001 SHALL have parameters: NET_DWIDTH, default 256, beat width; MAX_BDIMBITS, default 8, block-coordinate width; BEATS, default 16, beats per block (power of 2, >=2); RD_LAT, default 2, memory read latency in cycles.
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports are named clk and reset.
REQ-003 Ports, in order (name  direction  width  meaning):
- clk  in  1  sole clock
- reset  in  1  async active-low reset
- rdreq_valid / rdreq_ready  in / out  1 / 1  read-request handshake
- rdreq_blkx, rdreq_blky  in  MAX_BDIMBITS each  block coordinates
- rdreq_whichbufs  in  t_buftrio  buffer tag echoed on response
- rdreq_whichpage  in  1  page tag echoed on response
- rdresp_valid / rdresp_ready  out / in  1 / 1  response-stream handshake
- rdresp_data  out  NET_DWIDTH  block beat
- rdresp_whichbufs, rdresp_whichpage  out  t_buftrio, 1  echoed tags
- rdresp_sop, rdresp_eop  out  1 each  first/last beat
- wrreq_valid / wrreq_ready  in / out  1 / 1  write-stream handshake
- wrreq_data  in  NET_DWIDTH  beat
- wrreq_x, wrreq_y  in  MAX_BDIMBITS each  block coordinates (sampled on sop)
- wrreq_sop, wrreq_eop  in  1 each  packet delimiters
- mem_rd_en, mem_rd_addr, mem_rd_data  out, out, in  1, AW, NET_DWIDTH  read port; AW = 2*MAX_BDIMBITS+log2(BEATS)
- mem_wr_en, mem_wr_addr, mem_wr_data  out  1, AW, NET_DWIDTH  write port
- err_pkt  out  1  sticky write-framing error

Function
REQ-004 Memory address SHALL be {y, x, beat}, y most significant.
REQ-005 Read FSM states SHALL be IDLE and STREAM; rdreq_ready = 1 only in IDLE.
REQ-006 In IDLE, rdreq_valid&rdreq_ready SHALL latch blkx, blky, whichbufs, whichpage, clear issue and send counters, and enter STREAM next cycle.
REQ-007 In STREAM, mem_rd_en SHALL pulse for beats 0..BEATS-1 in order, one per cycle, only when (in-flight reads + response FIFO occupancy) < RD_LAT+2.
REQ-008 mem_rd_data SHALL be captured exactly RD_LAT cycles after its mem_rd_en into a response FIFO of depth RD_LAT+2; the FIFO SHALL never overflow.
REQ-009 rdresp_valid = FIFO non-empty; rdresp_data = FIFO head; whichbufs/whichpage = latched tags; sop = 1 on send-count 0; eop = 1 on send-count BEATS-1.
REQ-010 A beat is consumed on rdresp_valid&rdresp_ready; consuming the eop beat SHALL return the FSM to IDLE next cycle.
REQ-011 With rdresp_ready held 1, latency SHALL be: accept at cycle T, first mem_rd_en at T+1, first rdresp_valid at T+2+RD_LAT, one beat per cycle thereafter, no bubbles.
REQ-012 rdresp_valid deasserted by rdresp_ready=0 SHALL NOT occur; data, sop, eop, and tags SHALL stay stable while valid&!ready.
REQ-013 wrreq_ready SHALL be constant 1 out of reset; write path states are WIDLE and WBODY.
REQ-014 WIDLE: a beat with sop SHALL latch x,y, write beat 0 (same-cycle mem_wr_en, combinational from input), set count=1, enter WBODY; sop&eop together SHALL write the beat, set err_pkt, stay WIDLE; a beat without sop SHALL be dropped and set err_pkt.
REQ-015 WBODY: each beat SHALL write at count then increment; eop at count BEATS-1 returns to WIDLE; eop at any other count writes, sets err_pkt, returns WIDLE; non-eop beat at count BEATS-1 writes, sets err_pkt, returns WIDLE.
REQ-016 WBODY beat with sop SHALL set err_pkt and restart as in REQ-014 with the new x,y.
REQ-017 Same-cycle read and write to one address SHALL return old data (memory read-before-write); no other ordering is guaranteed.

Reset
REQ-018 reset low SHALL asynchronously force: both FSMs idle, counters and FIFO cleared, rdreq_ready=0 while asserted then 1 after release, rdresp_valid=0, mem_rd_en=0, mem_wr_en=0, err_pkt=0.
REQ-019 Reset mid-packet SHALL discard in-flight reads and partial write packets; no beat is emitted after reset from a pre-reset request.

Verification
REQ-020 BEATS=16, RD_LAT=2: rdreq x=3,y=5,page=1 at T, ready=1 -> mem_rd_addr 0x530..0x53F from T+1; rdresp beats T+4..T+19, sop at T+4, eop at T+19, page=1; rdreq_ready=1 at T+20.
REQ-021 rdresp_ready toggled 1,0,0,1 pseudo-randomly -> all 16 beats in order, FIFO occupancy <= 4, outputs stable while stalled.
REQ-022 Write packet x=2,y=7, 16 beats sop..eop -> mem_wr_addr 0x720..0x72F, err_pkt=0; readback matches written data.
REQ-023 Write sop then eop on 5th beat -> 5 writes, err_pkt=1, next clean packet still writes correctly.
REQ-024 Write beat without sop -> no mem_wr_en, err_pkt=1.
REQ-025 reset low at beat 8 of a read stream -> rdresp_valid=0 immediately; after release, new request streams from sop.

Source files
------------

// File: rtl/lu_blk_responder.sv
// Block responder: streams BEATS-beat blocks out of an external memory on request
// and writes framed beat packets into it. whichbufs is a 3-bit buffer-trio tag.
module lu_blk_responder #(
  parameter int NET_DWIDTH   = 256,
  parameter int MAX_BDIMBITS = 8,
  parameter int BEATS        = 16,
  parameter int RD_LAT       = 2,
  localparam int BW = $clog2(BEATS),
  localparam int AW = 2*MAX_BDIMBITS + BW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rdreq_valid,
  output logic                    rdreq_ready,
  input  logic [MAX_BDIMBITS-1:0] rdreq_blkx,
  input  logic [MAX_BDIMBITS-1:0] rdreq_blky,
  input  logic [2:0]              rdreq_whichbufs,
  input  logic                    rdreq_whichpage,
  output logic                    rdresp_valid,
  input  logic                    rdresp_ready,
  output logic [NET_DWIDTH-1:0]   rdresp_data,
  output logic [2:0]              rdresp_whichbufs,
  output logic                    rdresp_whichpage,
  output logic                    rdresp_sop,
  output logic                    rdresp_eop,
  input  logic                    wrreq_valid,
  output logic                    wrreq_ready,
  input  logic [NET_DWIDTH-1:0]   wrreq_data,
  input  logic [MAX_BDIMBITS-1:0] wrreq_x,
  input  logic [MAX_BDIMBITS-1:0] wrreq_y,
  input  logic                    wrreq_sop,
  input  logic                    wrreq_eop,
  output logic                    mem_rd_en,
  output logic [AW-1:0]           mem_rd_addr,
  input  logic [NET_DWIDTH-1:0]   mem_rd_data,
  output logic                    mem_wr_en,
  output logic [AW-1:0]           mem_wr_addr,
  output logic [NET_DWIDTH-1:0]   mem_wr_data,
  output logic                    err_pkt
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} rd_state_t;
  typedef enum logic {WIDLE, WBODY} wr_state_t;

  rd_state_t               rd_state, rd_state_nx;
  logic [MAX_BDIMBITS-1:0] req_x, req_y;
  logic [2:0]              req_bufs;
  logic                    req_page;
  logic [BW:0]             issue_cnt;
  logic [BW-1:0]           send_cnt;

  logic [RD_LAT-1:0]       rd_pipe;
  logic [CW-1:0]           inflight, occ;
  logic [CW:0]             committed;
  logic [NET_DWIDTH-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;

  logic accept, rd_issue, capture, pop;

  assign accept    = rdreq_valid & rdreq_ready;
  assign committed = (CW+1)'(inflight) + (CW+1)'(occ);
  assign rd_issue  = (rd_state == STREAM) && (issue_cnt < (BW+1)'(BEATS)) &&
                     (committed < (CW+1)'(DEPTH));
  assign capture   = rd_pipe[RD_LAT-1];
  assign pop       = rdresp_valid & rdresp_ready;

  // Held low during reset so no request is taken before the block is live
  assign rdreq_ready      = (rd_state == IDLE) & reset;
  assign mem_rd_en        = rd_issue;
  assign mem_rd_addr      = {req_y, req_x, issue_cnt[BW-1:0]};
  assign rdresp_valid     = (occ != '0);
  assign rdresp_data      = fifo_mem[rd_ptr];
  assign rdresp_whichbufs = req_bufs;
  assign rdresp_whichpage = req_page;
  assign rdresp_sop       = (send_cnt == '0);
  assign rdresp_eop       = (send_cnt == BW'(BEATS-1));

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      IDLE:    if (accept) rd_state_nx = STREAM;
      STREAM:  if (pop && rdresp_eop) rd_state_nx = IDLE;
      default: rd_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state  <= IDLE;
      req_x     <= '0;
      req_y     <= '0;
      req_bufs  <= '0;
      req_page  <= 1'b0;
      issue_cnt <= '0;
      send_cnt  <= '0;
    end else begin
      rd_state <= rd_state_nx;
      if (accept) begin
        req_x     <= rdreq_blkx;
        req_y     <= rdreq_blky;
        req_bufs  <= rdreq_whichbufs;
        req_page  <= rdreq_whichpage;
        issue_cnt <= '0;
        send_cnt  <= '0;
      end else begin
        if (rd_issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)      send_cnt  <= send_cnt + 1'b1;
      end
    end
  end

  // Issue gating on inflight+occ guarantees every returning beat has a FIFO slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe  <= '0;
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      case ({rd_issue, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({capture, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (capture) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  wr_state_t               wr_state, wr_state_nx;
  logic [MAX_BDIMBITS-1:0] wr_x, wr_y, wr_x_nx, wr_y_nx;
  logic [BW-1:0]           wr_cnt, wr_cnt_nx;
  logic                    wr_fire, err_set;

  assign wrreq_ready = reset;
  assign wr_fire     = wrreq_valid & wrreq_ready;
  assign mem_wr_data = wrreq_data;

  // A sop always starts a fresh packet; framing faults write what they can and flag
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = {wr_y, wr_x, wr_cnt};
    wr_state_nx = wr_state;
    wr_x_nx     = wr_x;
    wr_y_nx     = wr_y;
    wr_cnt_nx   = wr_cnt;
    err_set     = 1'b0;
    if (wr_fire) begin
      if (wrreq_sop) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = {wrreq_y, wrreq_x, {BW{1'b0}}};
        wr_x_nx     = wrreq_x;
        wr_y_nx     = wrreq_y;
        wr_cnt_nx   = BW'(1);
        err_set     = wrreq_eop | (wr_state == WBODY);
        wr_state_nx = wrreq_eop ? WIDLE : WBODY;
      end else if (wr_state == WIDLE) begin
        err_set = 1'b1;
      end else begin
        mem_wr_en = 1'b1;
        wr_cnt_nx = wr_cnt + 1'b1;
        if (wrreq_eop || (wr_cnt == BW'(BEATS-1))) begin
          wr_state_nx = WIDLE;
          err_set     = !(wrreq_eop && (wr_cnt == BW'(BEATS-1)));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state <= WIDLE;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_cnt   <= '0;
      err_pkt  <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      wr_x     <= wr_x_nx;
      wr_y     <= wr_y_nx;
      wr_cnt   <= wr_cnt_nx;
      if (err_set) err_pkt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lu_blk_responder.sv
// Self-checking bench for lu_blk_responder: external memory model plus a
// block-level reference of expected memory contents and write-framing rules.
module tb_lu_blk_responder;

  localparam int DW = 64;
  localparam int BB = 4;
  localparam int NB = 16;
  localparam int RL = 2;
  localparam int BW = 4;
  localparam int AW = 2*BB + BW;

  logic          clk;
  logic          reset;
  logic          rdreq_valid, rdreq_ready;
  logic [BB-1:0] rdreq_blkx, rdreq_blky;
  logic [2:0]    rdreq_whichbufs;
  logic          rdreq_whichpage;
  logic          rdresp_valid, rdresp_ready;
  logic [DW-1:0] rdresp_data;
  logic [2:0]    rdresp_whichbufs;
  logic          rdresp_whichpage, rdresp_sop, rdresp_eop;
  logic          wrreq_valid, wrreq_ready;
  logic [DW-1:0] wrreq_data;
  logic [BB-1:0] wrreq_x, wrreq_y;
  logic          wrreq_sop, wrreq_eop;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          err_pkt;

  int n_checks = 0;
  int n_fail   = 0;

  lu_blk_responder #(
    .NET_DWIDTH(DW), .MAX_BDIMBITS(BB), .BEATS(NB), .RD_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .rdreq_valid(rdreq_valid), .rdreq_ready(rdreq_ready),
    .rdreq_blkx(rdreq_blkx), .rdreq_blky(rdreq_blky),
    .rdreq_whichbufs(rdreq_whichbufs), .rdreq_whichpage(rdreq_whichpage),
    .rdresp_valid(rdresp_valid), .rdresp_ready(rdresp_ready),
    .rdresp_data(rdresp_data), .rdresp_whichbufs(rdresp_whichbufs),
    .rdresp_whichpage(rdresp_whichpage), .rdresp_sop(rdresp_sop), .rdresp_eop(rdresp_eop),
    .wrreq_valid(wrreq_valid), .wrreq_ready(wrreq_ready), .wrreq_data(wrreq_data),
    .wrreq_x(wrreq_x), .wrreq_y(wrreq_y), .wrreq_sop(wrreq_sop), .wrreq_eop(wrreq_eop),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .err_pkt(err_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {20'hB10C0, a, 20'h5EED0, a};
  endfunction

  // External memory: read-before-write, data returned RL cycles after the read enable
  logic [DW-1:0] mem     [1<<AW];
  bit            mem_vld [1<<AW];
  logic [DW-1:0] rpipe   [RL];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr]     <= mem_wr_data;
      mem_vld[mem_wr_addr] <= 1'b1;
    end
    rpipe[0] <= mem_rd_en ? (mem_vld[mem_rd_addr] ? mem[mem_rd_addr] : init_val(mem_rd_addr)) : '0;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rd_data = rpipe[RL-1];

  // Reference: expected memory contents and the write-framing state
  logic [DW-1:0] exp_mem [1<<AW];
  bit            exp_vld [1<<AW];
  bit            m_in_pkt, m_err;
  int            m_cnt;
  logic [BB-1:0] m_x, m_y;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return exp_vld[a] ? exp_mem[a] : init_val(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    rdreq_valid = 1'b0;
    wrreq_valid = 1'b0;
    rdresp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One write beat; body beats carry junk coordinates that must be ignored
  task automatic applyStimulus(input bit sop, input bit eop, input logic [BB-1:0] x, input logic [BB-1:0] y);
    logic [DW-1:0] d;
    bit            exp_en;
    logic [AW-1:0] exp_a;
    d = {$urandom, $urandom};
    @(negedge clk);
    wrreq_valid = 1'b1;
    wrreq_sop   = sop;
    wrreq_eop   = eop;
    wrreq_x     = x;
    wrreq_y     = y;
    wrreq_data  = d;
    #1;
    exp_en = 1'b1;
    exp_a  = '0;
    if (sop) begin
      exp_a = {y, x, {BW{1'b0}}};
      if (eop || m_in_pkt) m_err = 1'b1;
      m_in_pkt = !eop;
      m_cnt = 1;
      m_x = x;
      m_y = y;
    end else if (!m_in_pkt) begin
      exp_en = 1'b0;
      m_err  = 1'b1;
    end else begin
      exp_a = {m_y, m_x, m_cnt[BW-1:0]};
      if (m_cnt == NB-1) begin
        if (!eop) m_err = 1'b1;
        m_in_pkt = 1'b0;
      end else if (eop) begin
        m_err    = 1'b1;
        m_in_pkt = 1'b0;
      end
      m_cnt++;
    end
    checkOutput("wr_en", mem_wr_en, exp_en);
    if (exp_en) begin
      checkOutput("wr_addr", mem_wr_addr, exp_a);
      checkOutput("wr_data", mem_wr_data, d);
      exp_mem[exp_a] = d;
      exp_vld[exp_a] = 1'b1;
    end
  endtask

  task automatic wr_idle();
    @(negedge clk);
    wrreq_valid = 1'b0;
    wrreq_sop   = 1'b0;
    wrreq_eop   = 1'b0;
    #1;
    checkOutput("wr_en_idle", mem_wr_en, 0);
    checkOutput("err_pkt", err_pkt, m_err);
  endtask

  task automatic send_pkt(input logic [BB-1:0] x, input logic [BB-1:0] y, input int n);
    for (int b = 0; b < n; b++)
      applyStimulus(b == 0, b == n-1, (b == 0) ? x : BB'($urandom), (b == 0) ? y : BB'($urandom));
    wr_idle();
  endtask

  task automatic run_read(input logic [BB-1:0] x, input logic [BB-1:0] y, input logic [2:0] bufs,
                          input logic page, input bit stall, input int stop_after);
    int            issued;
    int            got;
    int            k;
    bit            prev_stall;
    logic [AW-1:0] a;
    issued = 0;
    got = 0;
    k = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rdreq_valid     = 1'b1;
    rdreq_blkx      = x;
    rdreq_blky      = y;
    rdreq_whichbufs = bufs;
    rdreq_whichpage = page;
    rdresp_ready    = 1'b1;
    #1 checkOutput("rdreq_ready_idle", rdreq_ready, 1);
    @(posedge clk);
    while (got < stop_after && k < 300) begin
      @(negedge clk);
      k++;
      rdreq_valid     = 1'b0;
      rdreq_blkx      = BB'($urandom);
      rdreq_blky      = BB'($urandom);
      rdreq_whichbufs = 3'($urandom);
      rdreq_whichpage = 1'($urandom);
      rdresp_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput("rdreq_ready_busy", rdreq_ready, 0);
      if (!stall) begin
        checkOutput("rd_en_sched", mem_rd_en, (k >= 1 && k <= NB));
        checkOutput("resp_valid_sched", rdresp_valid, (k >= RL+2 && k <= RL+1+NB));
      end else if (prev_stall) begin
        checkOutput("valid_held", rdresp_valid, 1);
      end
      if (mem_rd_en) begin
        checkOutput("rd_addr", mem_rd_addr, {y, x, issued[BW-1:0]});
        issued++;
        checkOutput("rd_count", issued <= NB, 1);
        checkOutput("rd_outstanding", (issued - got) <= RL+2, 1);
      end
      if (rdresp_valid) begin
        a = {y, x, got[BW-1:0]};
        checkOutput("resp_data", rdresp_data, exp_rd(a));
        checkOutput("resp_sop", rdresp_sop, got == 0);
        checkOutput("resp_eop", rdresp_eop, got == NB-1);
        checkOutput("resp_bufs", rdresp_whichbufs, bufs);
        checkOutput("resp_page", rdresp_whichpage, page);
        if (rdresp_ready) got++;
        prev_stall = !rdresp_ready;
      end else begin
        prev_stall = 1'b0;
      end
    end
    if (got < stop_after) checkOutput("read_timeout", got, stop_after);
    if (got == NB) begin
      @(negedge clk);
      rdresp_ready = 1'b1;
      #1 checkOutput("rdreq_ready_after", rdreq_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    rdreq_valid = 1'b0; rdreq_blkx = '0; rdreq_blky = '0;
    rdreq_whichbufs = '0; rdreq_whichpage = 1'b0;
    rdresp_ready = 1'b1;
    wrreq_valid = 1'b0; wrreq_data = '0; wrreq_x = '0; wrreq_y = '0;
    wrreq_sop = 1'b0; wrreq_eop = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_rdreq_ready", rdreq_ready, 0);
    checkOutput("rst_rdresp_valid", rdresp_valid, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_wr_en", mem_wr_en, 0);
    checkOutput("rst_err", err_pkt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rdreq_ready_out_of_rst", rdreq_ready, 1);
    checkOutput("wrreq_ready_out_of_rst", wrreq_ready, 1);

    // Nominal latency, then a randomly stalled stream
    run_read(4'd3, 4'd5, 3'b101, 1'b1, 1'b0, NB);
    run_read(4'd9, 4'd1, 3'b010, 1'b0, 1'b1, NB);

    // Clean packet and readback
    send_pkt(4'd2, 4'd7, NB);
    run_read(4'd2, 4'd7, 3'b111, 1'b0, 1'b0, NB);

    // Short packet flags an error; the following clean packet still lands
    send_pkt(4'd1, 4'd1, 5);
    send_pkt(4'd6, 4'd2, NB);
    run_read(4'd6, 4'd2, 3'b001, 1'b1, 1'b1, NB);
    run_read(4'd1, 4'd1, 3'b100, 1'b0, 1'b0, NB);

    // Orphan beat is dropped
    do_reset();
    applyStimulus(1'b0, 1'b0, 4'd8, 4'd8);
    wr_idle();

    // Restart on sop inside a body, and an over-long packet without eop
    do_reset();
    for (int b = 0; b < 3; b++) applyStimulus(b == 0, 1'b0, 4'd9, 4'd9);
    send_pkt(4'd4, 4'd4, NB);
    for (int b = 0; b < NB+1; b++) applyStimulus(b == 0, 1'b0, 4'd5, 4'd12);
    wr_idle();
    run_read(4'd4, 4'd4, 3'b011, 1'b1, 1'b0, NB);
    run_read(4'd5, 4'd12, 3'b110, 1'b0, 1'b1, NB);

    // Random blocks, random tags, random back-pressure
    for (int r = 0; r < 4; r++) begin
      logic [BB-1:0] rx, ry;
      rx = BB'($urandom);
      ry = BB'($urandom);
      if ($urandom_range(0, 1) == 1) send_pkt(rx, ry, NB);
      run_read(rx, ry, 3'($urandom), 1'($urandom), 1'b1, NB);
    end

    // Reset in the middle of a read stream
    run_read(4'd10, 4'd3, 3'b101, 1'b1, 1'b0, 8);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_rdresp_valid", rdresp_valid, 0);
    checkOutput("midrst_rd_en", mem_rd_en, 0);
    checkOutput("midrst_rdreq_ready", rdreq_ready, 0);
    checkOutput("midrst_err", err_pkt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 checkOutput("postrst_no_stale", rdresp_valid, 0);
    end
    run_read(4'd11, 4'd14, 3'b010, 1'b0, 1'b0, NB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
